uart_rx: RTL and testbench

//  Receive end of the UART link driven by uart_tx. Frame: 1 start, 8 data (LSB first),

---
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx line, 16x-oversampled mid-bit sampling,
// 8 data bits LSB first with optional parity, one-cycle rx_valid with error status.

module uart_rx #(
  parameter bit          parity_en  = 1'b1,
  parameter bit          parity_odd = 1'b0,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       os_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e state_q, state_d;

  logic             rx_meta_q, rx_s_q, rx_prev_q;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_bit_q, par_bit_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;

  logic start_edge;
  logic mid_start;
  logic mid_bit;
  logic deliver;
  logic exp_par;

  // rx is asynchronous to clk; every decision below uses the synchronised rx_s_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Only a fresh high->low transition starts a frame, so a held-low break never retriggers.
  assign start_edge = rx_prev_q & ~rx_s_q;
  assign mid_start  = os_tick && (tick_cnt_q == TickMid);
  assign mid_bit    = os_tick && (tick_cnt_q == TickLast);
  assign deliver    = (state_q == StStop) && mid_bit;
  assign exp_par    = parity_odd ? ~^shift_q : ^shift_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (mid_start) begin
          state_d = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        if (mid_bit && (bit_cnt_q == 3'd7)) begin
          state_d = parity_en ? StParity : StStop;
        end
      end
      StParity: begin
        if (mid_bit) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (mid_bit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: counters, shift register and delivered status.
  always_comb begin
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_valid_d   = 1'b0;

    if (state_d != state_q) begin
      tick_cnt_d = '0;
    end else if (os_tick && (state_q != StIdle)) begin
      // Explicit wrap keeps non-power-of-two oversampling ratios correct.
      tick_cnt_d = (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + 1'b1;
    end

    if ((state_q == StStart) && mid_start) begin
      bit_cnt_d = 3'd0;
    end

    if ((state_q == StData) && mid_bit) begin
      shift_d   = {rx_s_q, shift_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    if ((state_q == StParity) && mid_bit) begin
      par_bit_d = rx_s_q;
    end

    if (deliver) begin
      rx_data_d    = shift_q;
      parity_err_d = parity_en & (par_bit_q != exp_par);
      frame_err_d  = ~rx_s_q;
      rx_valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q   <= '0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_bit_q    <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Output logic
  always_comb begin
    rx_busy    = (state_q != StIdle);
    rx_data    = rx_data_q;
    rx_valid   = rx_valid_q;
    parity_err = parity_err_q;
    frame_err  = frame_err_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances (even parity, odd parity, no parity) fed by a
// time-based serial transmitter model; expected frames are queued and matched on rx_valid.
`timescale 1ns/1ps

module tb_uart_rx;

  localparam real BitNs = 320.0;  // 16 os_ticks of 2 clk at 10 ns

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       os_tick = 1'b0;
  logic       rx_line    [3];
  logic [7:0] rx_data    [3];
  logic       rx_valid   [3];
  logic       parity_err [3];
  logic       frame_err  [3];
  logic       rx_busy    [3];

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_rx #(
      .parity_en (g != 2),
      .parity_odd(g == 1),
      .OVERSAMPLE(16)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .os_tick   (os_tick),
      .rx        (rx_line[g]),
      .rx_data   (rx_data[g]),
      .rx_valid  (rx_valid[g]),
      .parity_err(parity_err[g]),
      .frame_err (frame_err[g]),
      .rx_busy   (rx_busy[g])
    );
  end

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1 os_tick = 1'b1;
      @(posedge clk);
      #1 os_tick = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic lane_par(input int l);
    return l != 2;
  endfunction

  function automatic logic lane_odd(input int l);
    return l == 1;
  endfunction

  // Correct parity bit: makes the total count of ones even (or odd for the odd lane).
  function automatic logic good_par(input int l, input logic [7:0] b);
    logic ones_odd;
    ones_odd = (($countones(b) % 2) == 1);
    return ones_odd ^ lane_odd(l);
  endfunction

  function automatic int q_size(input int l);
    case (l)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop_exp(input int l);
    case (l)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic push_exp(input int l, input exp_t e);
    case (l)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Drives one frame; the line is left at the stop-bit value afterwards.
  task automatic send_frame(input int l, input logic [7:0] b, input logic par,
                            input logic stp, input real bns);
    exp_t e;
    e.d  = b;
    e.pe = lane_par(l) && (par != good_par(l, b));
    e.fe = !stp;
    push_exp(l, e);
    rx_line[l] = 1'b0;
    #(bns);
    for (int i = 0; i < 8; i++) begin
      rx_line[l] = b[i];
      #(bns);
    end
    if (lane_par(l)) begin
      rx_line[l] = par;
      #(bns);
    end
    rx_line[l] = stp;
    #(bns);
  endtask

  task automatic rand_lane(input int l, input int n);
    logic [7:0] b;
    int         skew;
    real        bns;
    for (int i = 0; i < n; i++) begin
      b    = 8'($urandom);
      skew = int'($urandom_range(0, 60)) - 30;
      bns  = BitNs * (1000.0 + real'(skew)) / 1000.0;
      send_frame(l, b, good_par(l, b), 1'b1, bns);
      #(BitNs * real'($urandom_range(0, 2)));
    end
  endtask

  // Every rx_valid pulse must match the oldest outstanding frame on its lane.
  always @(negedge clk) begin
    exp_t e;
    logic have;
    for (int l = 0; l < 3; l++) begin
      if (rx_valid[l] === 1'b1) begin
        have = (q_size(l) != 0);
        check_eq($sformatf("l%0d_frame_expected", l), 32'(have), 32'd1);
        if (have) begin
          e = pop_exp(l);
          check_eq($sformatf("l%0d_data", l), 32'(rx_data[l]), 32'(e.d));
          check_eq($sformatf("l%0d_parity_err", l), 32'(parity_err[l]), 32'(e.pe));
          check_eq($sformatf("l%0d_frame_err", l), 32'(frame_err[l]), 32'(e.fe));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b5;
    int         waited;
    for (int l = 0; l < 3; l++) rx_line[l] = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;

    @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      check_eq($sformatf("rst_data_l%0d", l), 32'(rx_data[l]), 32'h0);
      check_eq($sformatf("rst_valid_l%0d", l), 32'(rx_valid[l]), 32'h0);
      check_eq($sformatf("rst_pe_l%0d", l), 32'(parity_err[l]), 32'h0);
      check_eq($sformatf("rst_fe_l%0d", l), 32'(frame_err[l]), 32'h0);
      check_eq($sformatf("rst_busy_l%0d", l), 32'(rx_busy[l]), 32'h0);
    end
    #(BitNs);

    // Clean even-parity frame, then a wrong parity bit.
    send_frame(0, 8'hA5, 1'b0, 1'b1, BitNs);
    #(2 * BitNs);
    send_frame(0, 8'h3C, 1'b1, 1'b1, BitNs);
    #(2 * BitNs);
    check_eq("t2_pe_hold", 32'(parity_err[0]), 32'd1);

    // Odd parity lane: correct bit, then wrong bit.
    send_frame(1, 8'hA5, 1'b1, 1'b1, BitNs);
    send_frame(1, 8'h00, 1'b0, 1'b1, BitNs);
    #(2 * BitNs);

    // Stop bit low, break held, then a clean frame.
    send_frame(0, 8'h81, 1'b0, 1'b0, BitNs);
    #(3 * BitNs);
    rx_line[0] = 1'b1;
    #(2 * BitNs);
    send_frame(0, 8'h42, good_par(0, 8'h42), 1'b1, BitNs);
    #(2 * BitNs);
    check_eq("t3_pending", 32'(q_size(0)), 32'd0);

    // Short low glitch: false start.
    rx_line[0] = 1'b0;
    repeat (3) @(posedge os_tick);
    @(negedge clk);
    check_eq("t4_busy_start", 32'(rx_busy[0]), 32'd1);
    @(posedge os_tick);
    rx_line[0] = 1'b1;
    repeat (16) @(posedge os_tick);
    @(negedge clk);
    check_eq("t4_busy_idle", 32'(rx_busy[0]), 32'd0);
    #(2 * BitNs);

    // Reset during data bit 4 of 0x5A.
    b5 = 8'h5A;
    rx_line[0] = 1'b0;
    #(BitNs);
    for (int i = 0; i < 4; i++) begin
      rx_line[0] = b5[i];
      #(BitNs);
    end
    rx_line[0] = b5[4];
    #(BitNs / 2.0);
    @(negedge clk);
    check_eq("t5_busy_mid", 32'(rx_busy[0]), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("t5_rst_data", 32'(rx_data[0]), 32'h0);
    check_eq("t5_rst_valid", 32'(rx_valid[0]), 32'h0);
    check_eq("t5_rst_pe", 32'(parity_err[0]), 32'h0);
    check_eq("t5_rst_fe", 32'(frame_err[0]), 32'h0);
    check_eq("t5_rst_busy", 32'(rx_busy[0]), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    rx_line[0] = 1'b1;
    #(6 * BitNs);
    send_frame(0, 8'h5A, good_par(0, 8'h5A), 1'b1, BitNs);
    #(2 * BitNs);
    check_eq("t5_hold", 32'(rx_data[0]), 32'h5A);

    // No-parity lane, back to back.
    send_frame(2, 8'hFF, 1'b0, 1'b1, BitNs);
    send_frame(2, 8'h00, 1'b0, 1'b1, BitNs);
    #(2 * BitNs);
    check_eq("t6_pending", 32'(q_size(2)), 32'd0);

    // Random bytes with +/-3% transmitter skew on all lanes at once.
    fork
      rand_lane(0, 86);
      rand_lane(1, 85);
      rand_lane(2, 85);
    join

    waited = 0;
    while ((q_size(0) + q_size(1) + q_size(2)) != 0 && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    for (int l = 0; l < 3; l++) begin
      check_eq($sformatf("final_pending_l%0d", l), 32'(q_size(l)), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
